xif_copro_exec_unit: RTL and testbench

//  Consumes decoded coprocessor ops (copro_op from xif_copro_pkg::decoder_t) plus CPU operands.

---
 rtl/xif_copro_exec_unit.sv | 180 ++++++++++++++++++
 tb/tb_xif_copro_exec_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_copro_exec_unit.sv
// Coprocessor execute unit: in-order buffer of decoded ops awaiting commit/kill, a
// bit-manipulation datapath, and a registered valid/ready result port.
module xif_copro_exec_unit #(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 4,
    parameter int unsigned XLen    = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [1:0]         in_op_i,
    input  logic [XLen-1:0]    in_rs1_i,
    input  logic [XLen-1:0]    in_rs2_i,
    input  logic [IdWidth-1:0] in_id_i,
    input  logic [4:0]         in_rd_i,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [IdWidth-1:0] res_id_o,
    output logic [4:0]         res_rd_o,
    output logic [XLen-1:0]    res_data_o,
    output logic               busy_o
);

    // copro_op encoding shared with the decoder
    localparam logic [1:0] OpNone     = 2'd0;
    localparam logic [1:0] OpBitrev   = 2'd1;
    localparam logic [1:0] OpRotRight = 2'd2;
    localparam logic [1:0] OpRotLeft  = 2'd3;

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ShW  = $clog2(XLen);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [1:0]         ent_op  [Depth];
    logic [XLen-1:0]    ent_rs1 [Depth];
    logic [XLen-1:0]    ent_rs2 [Depth];
    logic [IdWidth-1:0] ent_id  [Depth];
    logic [4:0]         ent_rd  [Depth];

    logic [Depth-1:0] ent_valid, ent_commit, ent_kill;
    logic [Depth-1:0] ent_valid_nxt, ent_commit_nxt, ent_kill_nxt;

    logic [PtrW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CntW-1:0] count, count_nxt;

    logic push, pop, res_load, res_free;
    logic head_valid, head_commit, head_kill, new_match;

    logic               res_valid;
    logic [IdWidth-1:0] res_id;
    logic [4:0]         res_rd;
    logic [XLen-1:0]    res_data;

    logic [XLen-1:0]   head_rs1, exec_data;
    logic [ShW-1:0]    head_amt;
    logic [2*XLen-1:0] rot_r, rot_l;

    assign in_ready_o = count < DepthCnt;
    assign push       = in_valid_i && in_ready_o;
    assign head_valid = count != '0;
    assign head_commit = ent_commit[rd_ptr];
    assign head_kill   = ent_kill[rd_ptr];
    assign res_free   = !res_valid || res_ready_i;
    // Killed heads drain regardless of the result port; committed heads need a free slot.
    assign pop        = head_valid && (head_kill || (head_commit && res_free));
    assign res_load   = pop && !head_kill;
    assign new_match  = commit_valid_i && (in_id_i == commit_id_i);

    always_comb begin
        ent_valid_nxt  = ent_valid;
        ent_commit_nxt = ent_commit;
        ent_kill_nxt   = ent_kill;
        for (int i = 0; i < Depth; i++) begin
            if (commit_valid_i && ent_valid[i] && !ent_commit[i] && !ent_kill[i] &&
                (ent_id[i] == commit_id_i)) begin
                ent_commit_nxt[i] = !commit_kill_i;
                ent_kill_nxt[i]   = commit_kill_i;
            end
            if (pop && (rd_ptr == PtrW'(i))) begin
                ent_valid_nxt[i]  = 1'b0;
                ent_commit_nxt[i] = 1'b0;
                ent_kill_nxt[i]   = 1'b0;
            end
            if (push && (wr_ptr == PtrW'(i))) begin
                ent_valid_nxt[i]  = 1'b1;
                ent_commit_nxt[i] = new_match && !commit_kill_i;
                ent_kill_nxt[i]   = new_match && commit_kill_i;
            end
        end
    end

    always_comb begin
        wr_ptr_nxt = push ? wr_ptr + PtrW'(1) : wr_ptr;
        rd_ptr_nxt = pop ? rd_ptr + PtrW'(1) : rd_ptr;
        count_nxt  = count + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent_valid  <= '0;
            ent_commit <= '0;
            ent_kill   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            ent_valid  <= ent_valid_nxt;
            ent_commit <= ent_commit_nxt;
            ent_kill   <= ent_kill_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                ent_op[i]  <= OpNone;
                ent_rs1[i] <= '0;
                ent_rs2[i] <= '0;
                ent_id[i]  <= '0;
                ent_rd[i]  <= '0;
            end
        end else if (push) begin
            ent_op[wr_ptr]  <= in_op_i;
            ent_rs1[wr_ptr] <= in_rs1_i;
            ent_rs2[wr_ptr] <= in_rs2_i;
            ent_id[wr_ptr]  <= in_id_i;
            ent_rd[wr_ptr]  <= in_rd_i;
        end
    end

    // Rotations via a doubled operand so an amount of zero needs no special case.
    always_comb begin
        head_rs1  = ent_rs1[rd_ptr];
        head_amt  = ent_rs2[rd_ptr][ShW-1:0];
        rot_r     = {head_rs1, head_rs1} >> head_amt;
        rot_l     = {head_rs1, head_rs1} << head_amt;
        exec_data = '0;
        unique case (ent_op[rd_ptr])
            OpBitrev: begin
                for (int i = 0; i < XLen; i++) begin
                    exec_data[i] = head_rs1[XLen-1-i];
                end
            end
            OpRotRight: exec_data = rot_r[XLen-1:0];
            OpRotLeft:  exec_data = rot_l[2*XLen-1:XLen];
            default:    exec_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_rd    <= '0;
            res_data  <= '0;
        end else if (res_load) begin
            res_valid <= 1'b1;
            res_id    <= ent_id[rd_ptr];
            res_rd    <= ent_rd[rd_ptr];
            res_data  <= exec_data;
        end else if (res_valid && res_ready_i) begin
            res_valid <= 1'b0;
        end
    end

    assign res_valid_o = res_valid;
    assign res_id_o    = res_id;
    assign res_rd_o    = res_rd;
    assign res_data_o  = res_data;
    assign busy_o      = (count != '0) || res_valid;

endmodule

// File: tb/tb_xif_copro_exec_unit.sv
// Directed bench for xif_copro_exec_unit: latency, datapath ops, ordering, kill,
// back-pressure and mid-operation reset.
module tb_xif_copro_exec_unit;

    localparam logic [1:0] OpNone     = 2'd0;
    localparam logic [1:0] OpBitrev   = 2'd1;
    localparam logic [1:0] OpRotRight = 2'd2;
    localparam logic [1:0] OpRotLeft  = 2'd3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  in_op_i;
    logic [31:0] in_rs1_i;
    logic [31:0] in_rs2_i;
    logic [3:0]  in_id_i;
    logic [4:0]  in_rd_i;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [3:0]  res_id_o;
    logic [4:0]  res_rd_o;
    logic [31:0] res_data_o;
    logic        busy_o;

    int tests = 0;
    int failed = 0;

    xif_copro_exec_unit #(
        .Depth   (4),
        .IdWidth (4),
        .XLen    (32)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_op_i        (in_op_i),
        .in_rs1_i       (in_rs1_i),
        .in_rs2_i       (in_rs2_i),
        .in_id_i        (in_id_i),
        .in_rd_i        (in_rd_i),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_id_o       (res_id_o),
        .res_rd_o       (res_rd_o),
        .res_data_o     (res_data_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        in_valid_i     = 1'b0;
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic drive_push(input logic [1:0] op, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [3:0] id,
                              input logic [4:0] rd, input logic cmt);
        in_valid_i     = 1'b1;
        in_op_i        = op;
        in_rs1_i       = rs1;
        in_rs2_i       = rs2;
        in_id_i        = id;
        in_rd_i        = rd;
        commit_valid_i = cmt;
        commit_id_i    = id;
        commit_kill_i  = 1'b0;
    endtask

    task automatic drive_commit(input logic [3:0] id, input logic kill);
        in_valid_i     = 1'b0;
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    // Push with same-cycle commit into an empty unit; result appears after the second edge.
    task automatic run_one(input string tag, input logic [1:0] op, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] exp);
        drive_push(op, rs1, rs2, 4'd4, 5'd9, 1'b1);
        tick();
        idle();
        tick();
        check({tag, "_valid"}, {31'd0, res_valid_o}, 32'd1);
        check({tag, "_data"}, res_data_o, exp);
        tick();
    endtask

    initial begin
        rst_ni      = 1'b0;
        res_ready_i = 1'b0;
        in_op_i     = OpNone;
        in_rs1_i    = '0;
        in_rs2_i    = '0;
        in_id_i     = '0;
        in_rd_i     = '0;
        commit_id_i = '0;
        idle();
        #12;
        check("rst_res_valid", {31'd0, res_valid_o}, 32'd0);
        check("rst_res_id", {28'd0, res_id_o}, 32'd0);
        check("rst_res_rd", {27'd0, res_rd_o}, 32'd0);
        check("rst_res_data", res_data_o, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        res_ready_i = 1'b1;
        tick();

        // Minimum latency: BITREV with same-cycle commit
        drive_push(OpBitrev, 32'h0000_0001, 32'h0, 4'd3, 5'd7, 1'b1);
        tick();
        idle();
        check("lat_e0_valid", {31'd0, res_valid_o}, 32'd0);
        check("lat_e0_busy", {31'd0, busy_o}, 32'd1);
        tick();
        check("lat_e1_valid", {31'd0, res_valid_o}, 32'd1);
        check("lat_e1_data", res_data_o, 32'h8000_0000);
        check("lat_e1_id", {28'd0, res_id_o}, 32'd3);
        check("lat_e1_rd", {27'd0, res_rd_o}, 32'd7);
        tick();
        check("lat_drain_valid", {31'd0, res_valid_o}, 32'd0);
        check("lat_drain_busy", {31'd0, busy_o}, 32'd0);

        run_one("rotr4", OpRotRight, 32'h0000_00F1, 32'h0000_0024, 32'h1000_000F);
        run_one("rotl0", OpRotLeft, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001);
        run_one("rotl1", OpRotLeft, 32'h8000_0001, 32'h0000_0021, 32'h0000_0003);
        run_one("bitrev", OpBitrev, 32'h1234_5678, 32'h0, 32'h1E6A_2C48);
        run_one("none", OpNone, 32'hDEAD_BEEF, 32'h5, 32'h0000_0000);

        // In-order: commit 3, 2, then 1
        for (int i = 1; i <= 3; i++) begin
            drive_push(OpRotLeft, 32'hA0 + 32'(i), 32'h0, 4'(i), 5'(i), 1'b0);
            tick();
        end
        idle();
        check("ord_wait0", {31'd0, res_valid_o}, 32'd0);
        drive_commit(4'd3, 1'b0);
        tick();
        idle();
        tick();
        check("ord_wait3", {31'd0, res_valid_o}, 32'd0);
        drive_commit(4'd2, 1'b0);
        tick();
        idle();
        tick();
        check("ord_wait2", {31'd0, res_valid_o}, 32'd0);
        drive_commit(4'd1, 1'b0);
        tick();
        idle();
        check("ord_wait1", {31'd0, res_valid_o}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("ord_valid", {31'd0, res_valid_o}, 32'd1);
            check("ord_id", {28'd0, res_id_o}, 32'(i));
            check("ord_data", res_data_o, 32'hA0 + 32'(i));
        end
        tick();
        check("ord_done", {31'd0, res_valid_o}, 32'd0);

        // Kill 5, commit 6
        drive_push(OpRotLeft, 32'hB5, 32'h0, 4'd5, 5'd5, 1'b0);
        tick();
        drive_push(OpRotLeft, 32'hB6, 32'h0, 4'd6, 5'd6, 1'b0);
        tick();
        drive_commit(4'd5, 1'b1);
        tick();
        drive_commit(4'd6, 1'b0);
        tick();
        idle();
        check("kill_none", {31'd0, res_valid_o}, 32'd0);
        tick();
        check("kill_valid", {31'd0, res_valid_o}, 32'd1);
        check("kill_id", {28'd0, res_id_o}, 32'd6);
        check("kill_data", res_data_o, 32'hB6);
        tick();
        check("kill_done", {31'd0, res_valid_o}, 32'd0);
        check("kill_busy", {31'd0, busy_o}, 32'd0);

        // Back-pressure: one held result plus a full buffer
        res_ready_i = 1'b0;
        drive_push(OpRotLeft, 32'hC8, 32'h0, 4'd8, 5'd8, 1'b1);
        tick();
        idle();
        tick();
        check("full_first", {28'd0, res_id_o}, 32'd8);
        for (int i = 9; i <= 12; i++) begin
            drive_push(OpRotLeft, 32'hC0 + 32'(i), 32'h0, 4'(i), 5'(i), 1'b1);
            tick();
        end
        idle();
        check("full_ready", {31'd0, in_ready_o}, 32'd0);
        drive_push(OpRotLeft, 32'hCD, 32'h0, 4'd13, 5'd13, 1'b1);
        tick();
        idle();
        check("full_refused", {31'd0, in_ready_o}, 32'd0);
        check("full_hold_valid", {31'd0, res_valid_o}, 32'd1);
        check("full_hold_id", {28'd0, res_id_o}, 32'd8);
        check("full_hold_data", res_data_o, 32'hC8);
        res_ready_i = 1'b1;
        for (int i = 9; i <= 12; i++) begin
            tick();
            check("drain_valid", {31'd0, res_valid_o}, 32'd1);
            check("drain_id", {28'd0, res_id_o}, 32'(i));
            check("drain_data", res_data_o, 32'hC0 + 32'(i));
        end
        tick();
        check("drain_done", {31'd0, res_valid_o}, 32'd0);
        check("drain_busy", {31'd0, busy_o}, 32'd0);
        check("drain_ready", {31'd0, in_ready_o}, 32'd1);

        // Reset with three entries and a pending result
        res_ready_i = 1'b0;
        drive_push(OpRotLeft, 32'hD0, 32'h0, 4'd14, 5'd14, 1'b1);
        tick();
        idle();
        tick();
        check("mrst_pending", {31'd0, res_valid_o}, 32'd1);
        drive_push(OpRotLeft, 32'hD1, 32'h0, 4'd15, 5'd15, 1'b0);
        tick();
        drive_push(OpRotLeft, 32'hD2, 32'h0, 4'd0, 5'd0, 1'b0);
        tick();
        drive_push(OpRotLeft, 32'hD3, 32'h0, 4'd1, 5'd1, 1'b0);
        tick();
        idle();
        #2;
        rst_ni = 1'b0;
        #1;
        check("mrst_valid", {31'd0, res_valid_o}, 32'd0);
        check("mrst_busy", {31'd0, busy_o}, 32'd0);
        check("mrst_ready", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        res_ready_i = 1'b1;
        drive_commit(4'd15, 1'b0);
        tick();
        idle();
        tick();
        tick();
        check("mrst_after_valid", {31'd0, res_valid_o}, 32'd0);
        check("mrst_after_busy", {31'd0, busy_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
